// File: rtl/fb_scanout_if.sv
// fb_scanout_if: framebuffer read port plus video output bundle.
// master = scanout engine, slave = framebuffer RAM / display sink.
`timescale 1ns/1ps
interface fb_scanout_if;
  logic [10:0] rd_addr;
  logic [5:0]  rd_data;
  logic [5:0]  rgb;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        frame_start;

  modport master (
    output rd_addr,
    input  rd_data,
    output rgb,
    output hsync,
    output vsync,
    output de,
    output frame_start
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  rgb,
    input  hsync,
    input  vsync,
    input  de,
    input  frame_start
  );
endinterface

// File: rtl/fb_scanout.sv
// fb_scanout: raster timing generator scanning a 64x32 cell framebuffer,
// each cell upscaled SCALE_X x SCALE_Y, with a 3-clk read pipeline.
`timescale 1ns/1ps
module fb_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SCALE_X  = 10,
  parameter int SCALE_Y  = 15
) (
  input  logic         clk,
  input  logic         rst,
  fb_scanout_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int XW = $clog2(SCALE_X + 1);
  localparam int YW = $clog2(SCALE_Y + 1);

  localparam logic [HW-1:0] H_MAX  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_MAX  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [XW-1:0] XS_MAX = XW'(SCALE_X - 1);
  localparam logic [YW-1:0] YS_MAX = YW'(SCALE_Y - 1);
  localparam logic [5:0]    COL_MAX = 6'd63;
  localparam logic [4:0]    ROW_MAX = 5'd31;

  typedef struct packed {
    logic vis;
    logic hs_n;
    logic vs_n;
    logic fs;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{
    vis:  1'b0,
    hs_n: 1'b1,
    vs_n: 1'b1,
    fs:   1'b0
  };

  // Async assert, release on a clock edge so every counter starts together.
  logic rst_n_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_n_q <= 1'b0;
    else      rst_n_q <= 1'b1;
  end

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [XW-1:0] xs_q, xs_d;
  logic [YW-1:0] ys_q, ys_d;
  logic [5:0]    col_q, col_d;
  logic [4:0]    row_q, row_d;

  logic h_last;
  logic v_last;
  logic h_act;
  logic v_act;
  logic vis;
  ctl_t ctl0;

  assign h_last = (hcnt_q == H_MAX);
  assign v_last = (vcnt_q == V_MAX);
  assign h_act  = (hcnt_q < H_VIS);
  assign v_act  = (vcnt_q < V_VIS);
  assign vis    = h_act && v_act;

  assign ctl0 = '{
    vis:  vis,
    hs_n: !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END)),
    vs_n: !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END)),
    fs:   (hcnt_q == '0) && (vcnt_q == '0)
  };

  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (h_last) begin
      hcnt_d = '0;
      vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
    end
  end

  // Column stepping: one cell per SCALE_X visible clocks, saturating.
  always_comb begin
    xs_d  = xs_q;
    col_d = col_q;
    unique case (1'b1)
      h_last: begin
        xs_d  = '0;
        col_d = '0;
      end
      vis: begin
        if (xs_q == XS_MAX) begin
          xs_d = '0;
          if (col_q != COL_MAX)
            col_d = col_q + 1'b1;
        end else begin
          xs_d = xs_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ys_d  = ys_q;
    row_d = row_q;
    unique case (1'b1)
      h_last && v_last: begin
        ys_d  = '0;
        row_d = '0;
      end
      h_last && v_act: begin
        if (ys_q == YS_MAX) begin
          ys_d = '0;
          if (row_q != ROW_MAX)
            row_d = row_q + 1'b1;
        end else begin
          ys_d = ys_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      xs_q   <= '0;
      ys_q   <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      xs_q   <= xs_d;
      ys_q   <= ys_d;
      col_q  <= col_d;
      row_q  <= row_d;
    end
  end

  logic [10:0] rd_addr_q;
  ctl_t        ctl1_q;
  ctl_t        ctl2_q;
  ctl_t        ctl3_q;
  logic [5:0]  rgb_q;

  // Stage 1 address, stage 2 RAM latency, stage 3 output register.
  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      rd_addr_q <= '0;
      ctl1_q    <= CTL_IDLE;
      ctl2_q    <= CTL_IDLE;
      ctl3_q    <= CTL_IDLE;
      rgb_q     <= '0;
    end else begin
      rd_addr_q <= {row_q, vis ? col_q : 6'd0};
      ctl1_q    <= ctl0;
      ctl2_q    <= ctl1_q;
      ctl3_q    <= ctl2_q;
      rgb_q     <= ctl2_q.vis ? bus.rd_data : 6'd0;
    end
  end

  assign bus.rd_addr     = rd_addr_q;
  assign bus.rgb         = rgb_q;
  assign bus.de          = ctl3_q.vis;
  assign bus.hsync       = ctl3_q.hs_n;
  assign bus.vsync       = ctl3_q.vs_n;
  assign bus.frame_start = ctl3_q.fs;

endmodule
